// File: rtl/pipe_stall_ctrl_if.sv
// Signal bundle between the pipeline stages and the stall/flush sequencer.
// The master drives hazard and stall requests. The slave returns the stall and flush controls.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned STAT_W = 16
);
  logic              id_reg1_read_i;
  logic [4:0]        id_reg1_addr_i;
  logic              id_reg2_read_i;
  logic [4:0]        id_reg2_addr_i;
  logic              ex_is_load_i;
  logic              ex_wreg_i;
  logic [4:0]        ex_wd_i;
  logic              ex_mc_start_i;
  logic [CNT_W-1:0]  ex_mc_cycles_i;
  logic              stallreq_if_i;
  logic              stallreq_mem_i;
  logic              flush_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic              busy_o;
  logic              err_o;
  logic [STAT_W-1:0] stall_cnt_o;

  modport master (
    output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
    output ex_is_load_i, ex_wreg_i, ex_wd_i, ex_mc_start_i, ex_mc_cycles_i,
    output stallreq_if_i, stallreq_mem_i, flush_i,
    input  stall_o, flush_o, busy_o, err_o, stall_cnt_o
  );

  modport slave (
    input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
    input  ex_is_load_i, ex_wreg_i, ex_wd_i, ex_mc_start_i, ex_mc_cycles_i,
    input  stallreq_if_i, stallreq_mem_i, flush_i,
    output stall_o, flush_o, busy_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: load-use detection, multi-cycle EX hold,
// deepest-wins stall arbitration and exception flush for the 5-stage pipe.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned STAT_W = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                err_q, err_d;
  logic [STAT_W-1:0]   cnt_q, cnt_d;
  logic                lu, mc, len_ok;
  logic [5:0]          stall;

  // Register 0 is hardwired, so it can never be a load-use hazard.
  always_comb begin
    lu = bus.ex_is_load_i & bus.ex_wreg_i & (bus.ex_wd_i != 5'd0) &
         ((bus.id_reg1_read_i & (bus.id_reg1_addr_i == bus.ex_wd_i)) |
          (bus.id_reg2_read_i & (bus.id_reg2_addr_i == bus.ex_wd_i)));
  end

  assign len_ok = (bus.ex_mc_cycles_i >= CNT_W'(2));
  assign mc     = (state_q == StIdle) ? (bus.ex_mc_start_i & len_ok) : (rem_q != '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    if (bus.flush_i) begin
      state_d = StIdle;
      rem_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.ex_mc_start_i && len_ok) begin
            state_d = StBusy;
            rem_d   = bus.ex_mc_cycles_i - CNT_W'(2);
          end
        end
        StBusy: begin
          if (bus.ex_mc_start_i) err_d = 1'b1;
          // Keep counting under a MEM stall: the EX unit keeps computing.
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          else             state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Deepest requester wins; flush overrides everything.
  always_comb begin
    stall = 6'b000000;
    if (!rst && !bus.flush_i) begin
      if (bus.stallreq_mem_i)     stall = 6'b011111;
      else if (mc)                stall = 6'b001111;
      else if (lu)                stall = 6'b000111;
      else if (bus.stallreq_if_i) stall = 6'b000011;
      else                        stall = 6'b000000;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall != 6'b000000) && (cnt_q != '1)) cnt_d = cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = bus.flush_i & ~rst;
  assign bus.busy_o      = ~rst & (state_q == StBusy);
  assign bus.err_o       = err_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a combinational vector table plus
// hand-written multi-cycle sequences for BUSY, flush, error and saturation.
module tb_pipe_stall_ctrl;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned STAT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r1rd;
    logic [4:0] r1a;
    logic       r2rd;
    logic [4:0] r2a;
    logic       ld;
    logic       wr;
    logic [4:0] wd;
    logic       ifq;
    logic       memq;
    logic       fl;
    logic [5:0] stall;
    logic       flush;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.id_reg1_read_i = 1'b0;
    bus.id_reg1_addr_i = 5'd0;
    bus.id_reg2_read_i = 1'b0;
    bus.id_reg2_addr_i = 5'd0;
    bus.ex_is_load_i   = 1'b0;
    bus.ex_wreg_i      = 1'b0;
    bus.ex_wd_i        = 5'd0;
    bus.ex_mc_start_i  = 1'b0;
    bus.ex_mc_cycles_i = '0;
    bus.stallreq_if_i  = 1'b0;
    bus.stallreq_mem_i = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic start_mc(input int n);
    bus.ex_mc_start_i  = 1'b1;
    bus.ex_mc_cycles_i = CNT_W'(n);
  endtask

  initial begin
    logic [5:0] exp_st[5];
    logic       exp_bz[5];

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_st[5];
    logic       exp_bz[5];

    //              r1rd r1a   r2rd r2a   ld   wr   wd    if   mem  fl   stall      flush
    vecs[0]  = '{1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
    vecs[2]  = '{1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0};
    vecs[3]  = '{1'b1, 5'd7, 1'b0, 5'd3, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
    vecs[4]  = '{1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
    vecs[5]  = '{1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b000011, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 6'b000111, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 6'b011111, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 6'b000000, 1'b1};
    vecs[10] = '{1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};

    // Reset state: outputs forced low even with requests present.
    clr_in();
    bus.stallreq_if_i = 1'b1;
    bus.flush_i       = 1'b1;
    #3;
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_flush", 32'(bus.flush_o), 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);
    chk("rst_cnt", 32'(bus.stall_cnt_o), 32'h0);
    clr_in();
    rst = 1'b0;
    tick();

    // Combinational vectors from IDLE.
    for (int i = 0; i < 11; i++) begin
      bus.id_reg1_read_i = vecs[i].r1rd;
      bus.id_reg1_addr_i = vecs[i].r1a;
      bus.id_reg2_read_i = vecs[i].r2rd;
      bus.id_reg2_addr_i = vecs[i].r2a;
      bus.ex_is_load_i   = vecs[i].ld;
      bus.ex_wreg_i      = vecs[i].wr;
      bus.ex_wd_i        = vecs[i].wd;
      bus.stallreq_if_i  = vecs[i].ifq;
      bus.stallreq_mem_i = vecs[i].memq;
      bus.flush_i        = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_flush", i), 32'(bus.flush_o), 32'(vecs[i].flush));
      tick();
    end
    clr_in();

    // Multi-cycle N=4: three stalled cycles, busy for three cycles after start.
    do_reset();
    start_mc(4);
    exp_st = '{6'b001111, 6'b001111, 6'b001111, 6'b000000, 6'b000000};
    exp_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("mc4_stall%0d", k), 32'(bus.stall_o), 32'(exp_st[k]));
      chk($sformatf("mc4_busy%0d", k), 32'(bus.busy_o), 32'(exp_bz[k]));
      tick();
      if (k == 0) clr_in();
    end
    chk("mc4_cnt", 32'(bus.stall_cnt_o), 32'd3);

    // N=1 never stalls.
    do_reset();
    start_mc(1);
    @(negedge clk);
    chk("mc1_stall", 32'(bus.stall_o), 32'h0);
    tick();
    clr_in();
    @(negedge clk);
    chk("mc1_busy", 32'(bus.busy_o), 32'h0);
    chk("mc1_cnt", 32'(bus.stall_cnt_o), 32'h0);
    tick();

    // MEM stall while BUSY with rem=2; rem keeps counting down.
    do_reset();
    start_mc(4);
    @(negedge clk);
    chk("pri_start", 32'(bus.stall_o), 32'b001111);
    tick();
    clr_in();
    bus.stallreq_mem_i = 1'b1;
    @(negedge clk);
    chk("pri_mem", 32'(bus.stall_o), 32'b011111);
    tick();
    bus.stallreq_mem_i = 1'b0;
    @(negedge clk);
    chk("pri_after", 32'(bus.stall_o), 32'b001111);
    tick();
    @(negedge clk);
    chk("pri_release", 32'(bus.stall_o), 32'h0);
    chk("pri_rel_busy", 32'(bus.busy_o), 32'h1);
    tick();
    @(negedge clk);
    chk("pri_idle", 32'(bus.busy_o), 32'h0);
    chk("pri_cnt", 32'(bus.stall_cnt_o), 32'd3);
    tick();

    // Flush on the third stalled cycle of N=10, with a competing start.
    do_reset();
    start_mc(10);
    tick();
    clr_in();
    tick();
    bus.flush_i = 1'b1;
    start_mc(5);
    @(negedge clk);
    chk("fl_stall", 32'(bus.stall_o), 32'h0);
    chk("fl_flush", 32'(bus.flush_o), 32'h1);
    tick();
    clr_in();
    @(negedge clk);
    chk("fl_busy", 32'(bus.busy_o), 32'h0);
    chk("fl_stall2", 32'(bus.stall_o), 32'h0);
    chk("fl_flush2", 32'(bus.flush_o), 32'h0);
    chk("fl_err", 32'(bus.err_o), 32'h0);
    tick();

    // Start while BUSY: sticky error, original op length unchanged.
    do_reset();
    start_mc(4);
    tick();
    start_mc(10);
    @(negedge clk);
    chk("err_st1", 32'(bus.stall_o), 32'b001111);
    tick();
    clr_in();
    @(negedge clk);
    chk("err_set", 32'(bus.err_o), 32'h1);
    chk("err_st2", 32'(bus.stall_o), 32'b001111);
    tick();
    @(negedge clk);
    chk("err_rel", 32'(bus.stall_o), 32'h0);
    tick();
    @(negedge clk);
    chk("err_idle", 32'(bus.busy_o), 32'h0);
    repeat (3) tick();
    chk("err_sticky", 32'(bus.err_o), 32'h1);
    do_reset();
    chk("err_clr", 32'(bus.err_o), 32'h0);

    // Saturation of the 4-bit counter, then async reset mid-BUSY.
    bus.stallreq_if_i = 1'b1;
    @(negedge clk);
    chk("sat_stall", 32'(bus.stall_o), 32'b000011);
    repeat (20) tick();
    chk("sat_cnt", 32'(bus.stall_cnt_o), 32'd15);
    clr_in();
    start_mc(10);
    tick();
    clr_in();
    tick();
    chk("ar_pre_stall", 32'(bus.stall_o), 32'b001111);
    chk("ar_pre_busy", 32'(bus.busy_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_stall", 32'(bus.stall_o), 32'h0);
    chk("ar_busy", 32'(bus.busy_o), 32'h0);
    chk("ar_cnt", 32'(bus.stall_cnt_o), 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
